multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 135 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/execute/mem/writeback sequencing,
// memory wait timeout, and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic             mem_ready,
  input  logic             alu_zero,
  output logic [2:0]       state,
  output logic             ir_load,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_we,
  output logic             mem_to_reg,
  output logic             pc_en,
  output logic             pc_src,
  output logic             halted,
  output logic             err,
  output logic [2:0]       alu_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;
  localparam int         WAIT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t             state_q;
  logic [2:0]         op_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               timeout_hit;

  // A low mem_ready in this cycle would be the TIMEOUT-th consecutive one.
  assign timeout_hit = (wait_q == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (pc_en) cnt_q <= cnt_q + 1'b1;
      // The wait counter only survives cycles spent stalled in FETCH or MEM.
      wait_q <= '0;
      case (state_q)
        S_IDLE:   if (start) state_q <= S_FETCH;
        S_FETCH: begin
          if (mem_ready)        state_q <= S_DECODE;
          else if (timeout_hit) state_q <= S_ERROR;
          else                  wait_q  <= wait_q + 1'b1;
        end
        S_DECODE: begin
          op_q    <= opcode;
          state_q <= (opcode == OP_HALT) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          if (op_q == OP_LW || op_q == OP_SW) state_q <= S_MEM;
          else if (op_q == OP_BEQ)            state_q <= S_FETCH;
          else                                state_q <= S_WB;
        end
        S_MEM: begin
          if (mem_ready)        state_q <= (op_q == OP_LW) ? S_WB : S_FETCH;
          else if (timeout_hit) state_q <= S_ERROR;
          else                  wait_q  <= wait_q + 1'b1;
        end
        S_WB:     state_q <= S_FETCH;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_ERROR;
      endcase
    end
  end

  always_comb begin
    ir_load    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 1'b0;
    halted     = 1'b0;
    err        = 1'b0;
    alu_op     = 3'b000;
    case (state_q)
      S_FETCH: begin
        mem_rd  = 1'b1;
        ir_load = mem_ready;
      end
      S_EXEC: begin
        if (op_q == OP_BEQ) begin
          alu_op = 3'b001;
          pc_en  = 1'b1;
          pc_src = alu_zero;
        end else if (!op_q[2]) begin
          alu_op = op_q;
        end
      end
      S_MEM: begin
        mem_rd = (op_q == OP_LW);
        mem_wr = (op_q == OP_SW);
        pc_en  = mem_ready && (op_q == OP_SW);
      end
      S_WB: begin
        reg_we     = 1'b1;
        pc_en      = 1'b1;
        mem_to_reg = (op_q == OP_LW);
      end
      S_HALT:  halted = 1'b1;
      S_ERROR: err    = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expectations are queued as
// stimulus is driven and compared mid-cycle against the DUT outputs.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  localparam logic [2:0] S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3,
                         S_MEM = 4, S_WB = 5, S_HALT = 6, S_ERROR = 7;
  localparam logic [2:0] OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3,
                         OP_LW = 4, OP_SW = 5, OP_BEQ = 6, OP_HALT = 7;

  // Packed output vector: {ir_load, mem_rd, mem_wr, reg_we, mem_to_reg,
  // pc_en, pc_src, halted, err, alu_op[2:0]}
  localparam logic [11:0] IR = 12'h800, RD = 12'h400, WR = 12'h200,
                          WE = 12'h100, M2R = 12'h080, PCEN = 12'h040,
                          PCS = 12'h020, HLT = 12'h010, ERR = 12'h008;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    opcode = 3'b000;
  logic          mem_ready = 1'b0;
  logic          alu_zero = 1'b0;
  logic [2:0]    state;
  logic          ir_load, mem_rd, mem_wr, reg_we, mem_to_reg;
  logic          pc_en, pc_src, halted, err;
  logic [2:0]    alu_op;
  logic [CW-1:0] instr_count;
  logic [11:0]   obs;

  typedef struct {
    string         tag;
    logic [2:0]    st;
    logic [11:0]   outs;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  logic [CW-1:0] cnt_exp = '0;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(15), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .mem_ready(mem_ready), .alu_zero(alu_zero), .state(state),
    .ir_load(ir_load), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_we(reg_we),
    .mem_to_reg(mem_to_reg), .pc_en(pc_en), .pc_src(pc_src),
    .halted(halted), .err(err), .alu_op(alu_op), .instr_count(instr_count)
  );

  assign obs = {ir_load, mem_rd, mem_wr, reg_we, mem_to_reg, pc_en, pc_src,
                halted, err, alu_op};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue expectation, compare at negedge.
  task automatic cyc(input string tag, input logic s, input logic [2:0] op,
                     input logic mr, input logic az,
                     input logic [2:0] est, input logic [11:0] eo);
    exp_t e;
    start = s; opcode = op; mem_ready = mr; alu_zero = az;
    e.tag = tag; e.st = est; e.outs = eo; e.cnt = cnt_exp;
    sb.push_back(e);
    if (eo[6]) cnt_exp = cnt_exp + 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, "/state"}, 32'(state), 32'(e.st));
    chk({e.tag, "/outs"}, 32'(obs), 32'(e.outs));
    chk({e.tag, "/count"}, 32'(instr_count), 32'(e.cnt));
    $display("cyc %-12s st=%0d outs=%h cnt=%0d", e.tag, state, obs, instr_count);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cnt_exp = '0;
    cyc("reset", 1'b1, OP_HALT, 1'b1, 1'b1, S_IDLE, '0);
    rst = 1'b0;
    cyc("idle", 1'b0, OP_ADD, 1'b1, 1'b0, S_IDLE, '0);
    cyc("start", 1'b1, OP_ADD, 1'b0, 1'b0, S_IDLE, '0);
  endtask

  // Full instruction from FETCH; fl/ml = low mem_ready cycles before ready.
  // The opcode input is scrambled outside DECODE so only op_q may matter.
  task automatic do_instr(input logic [2:0] op, input logic az, input int fl, input int ml);
    logic [2:0]  nop;
    logic [11:0] eo;
    nop = ~op;
    for (int i = 0; i < fl; i++) cyc("fetch_wait", 1'b0, nop, 1'b0, 1'b0, S_FETCH, RD);
    cyc("fetch", 1'b0, nop, 1'b1, 1'b0, S_FETCH, IR | RD);
    cyc("decode", 1'b0, op, 1'b1, 1'b0, S_DECODE, '0);
    if (op == OP_HALT) begin
      for (int i = 0; i < 3; i++) cyc("halt", 1'b1, OP_ADD, 1'b1, 1'b1, S_HALT, HLT);
      return;
    end
    if (op == OP_BEQ)   eo = PCEN | (az ? PCS : 12'h000) | 12'h001;
    else if (op[2])     eo = '0;
    else                eo = {9'b0, op};
    cyc("exec", 1'b0, nop, 1'b1, az, S_EXEC, eo);
    if (op == OP_LW || op == OP_SW) begin
      for (int i = 0; i < ml; i++)
        cyc("mem_wait", 1'b0, nop, 1'b0, 1'b0, S_MEM, (op == OP_LW) ? RD : WR);
      cyc("mem_done", 1'b0, nop, 1'b1, 1'b0, S_MEM, (op == OP_LW) ? RD : (WR | PCEN));
    end
    if (op == OP_LW)      cyc("wb_lw", 1'b0, nop, 1'b1, 1'b0, S_WB, WE | PCEN | M2R);
    else if (!op[2])      cyc("wb", 1'b0, nop, 1'b1, 1'b0, S_WB, WE | PCEN);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    do_instr(OP_ADD, 1'b0, 0, 0);
    do_instr(OP_SUB, 1'b0, 0, 0);
    do_instr(OP_AND, 1'b1, 0, 0);
    do_instr(OP_OR,  1'b0, 0, 0);
    do_instr(OP_LW,  1'b0, 0, 2);
    do_instr(OP_SW,  1'b0, 1, 0);
    do_instr(OP_BEQ, 1'b1, 0, 0);
    do_instr(OP_BEQ, 1'b0, 0, 0);
    do_instr(OP_LW,  1'b0, 10, 14);
    do_instr(OP_ADD, 1'b0, 14, 0);
    // Fifteen consecutive lows in FETCH fault; inputs then ignored.
    for (int i = 0; i < 15; i++) cyc("to_fetch", 1'b0, OP_ADD, 1'b0, 1'b0, S_FETCH, RD);
    for (int i = 0; i < 3; i++) cyc("error", 1'b1, OP_BEQ, 1'b1, 1'b1, S_ERROR, ERR);

    // Reset in the middle of a LW memory wait.
    do_reset();
    do_instr(OP_ADD, 1'b0, 0, 0);
    cyc("fetch", 1'b0, OP_ADD, 1'b1, 1'b0, S_FETCH, IR | RD);
    cyc("decode", 1'b0, OP_LW, 1'b1, 1'b0, S_DECODE, '0);
    cyc("exec", 1'b0, OP_ADD, 1'b1, 1'b0, S_EXEC, '0);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("mid_mem_rd", 32'(mem_rd), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("async_rst_state", 32'(state), 32'(S_IDLE));
    chk("async_rst_count", 32'(instr_count), 32'd0);
    $display("cyc async_rst  st=%0d rd=%0d cnt=%0d", state, mem_rd, instr_count);
    @(posedge clk); #1;

    // Timeout in MEM.
    do_reset();
    cyc("fetch", 1'b0, OP_ADD, 1'b1, 1'b0, S_FETCH, IR | RD);
    cyc("decode", 1'b0, OP_SW, 1'b1, 1'b0, S_DECODE, '0);
    cyc("exec", 1'b0, OP_ADD, 1'b1, 1'b0, S_EXEC, '0);
    for (int i = 0; i < 15; i++) cyc("to_mem", 1'b0, OP_ADD, 1'b0, 1'b0, S_MEM, WR);
    cyc("error", 1'b1, OP_ADD, 1'b1, 1'b0, S_ERROR, ERR);

    // HALT keeps the count and ignores start.
    do_reset();
    do_instr(OP_ADD, 1'b0, 0, 0);
    do_instr(OP_HALT, 1'b0, 0, 0);

    // Counter wrap: sixteen branches through a 4-bit counter.
    do_reset();
    for (int i = 0; i < 16; i++) do_instr(OP_BEQ, i[0], 0, 0);
    chk("wrap_to_zero", 32'(instr_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
